// File: rtl/snes_pkg.sv
// Shared constants and helpers for the SNES button event block.
// Button order matches the controller wrapper: {A, RIGHT, LEFT, DOWN, UP, B}.
package snes_pkg;
  localparam int NUM_BUTTONS = 6;

  localparam int BTN_B     = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_A     = 5;

  localparam int EVT_VALID  = 15;
  localparam int EVT_PRESS  = 14;
  localparam int EVT_IDX_HI = 10;
  localparam int EVT_IDX_LO = 8;

  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

  // Index of the lowest set bit; callers only use it when some bit is set.
  function automatic logic [2:0] lowest_set(input btn_vec_t v);
    logic [2:0] idx;
    casez (v)
      6'b?????1: idx = 3'd0;
      6'b????10: idx = 3'd1;
      6'b???100: idx = 3'd2;
      6'b??1000: idx = 3'd3;
      6'b?10000: idx = 3'd4;
      6'b100000: idx = 3'd5;
      default:   idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [15:0] make_event(input logic [2:0] idx, input logic press,
                                             input btn_vec_t levels);
    logic [15:0] w;
    w = 16'h0000;
    w[EVT_VALID] = 1'b1;
    w[EVT_PRESS] = press;
    w[EVT_IDX_HI:EVT_IDX_LO] = idx;
    w[NUM_BUTTONS-1:0] = levels;
    return w;
  endfunction
endpackage

// File: rtl/snes_button_events_if.sv
// CPU-facing register bus of the button event block: event FIFO read port,
// debounced levels, stall flag and interrupt.
interface snes_button_events_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic [15:0]      rd_data;
  logic [CNT_W-1:0] count;
  logic [5:0]       state;
  logic             stall;
  logic             clr_stall;
  logic             irq;

  modport master (output rd_en, clr_stall, input rd_data, count, state, stall, irq);
  modport slave  (input rd_en, clr_stall, output rd_data, count, state, stall, irq);
endinterface

// File: rtl/snes_debounce.sv
// One button bit: two-flop synchronizer followed by a debounce counter that
// flips the output only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module snes_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronizer and debounce counter; counting restarts whenever sync agrees.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      deb_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      if (sync_r == deb_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        deb_r <= ~deb_r;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign dout = deb_r;
endmodule

// File: rtl/snes_button_events.sv
// Debounced SNES buttons turned into press/release event words queued in a FIFO.
// Optional registered interrupt enabled by SNES_BUTTON_EVENTS_IRQ_EN.
module snes_button_events
  import snes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           buttons,
  snes_button_events_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  btn_vec_t         deb_s;
  btn_vec_t         rep_r;
  btn_vec_t         next_rep_s;
  logic [2:0]       idx_s;
  logic             hit_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [15:0]      evt_s;
  logic [15:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             stall_r;
  logic [15:0]      rd_data_r;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_deb
    snes_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (buttons[g]),
      .dout (deb_s[g])
    );
  end

  // Scan: lowest-index unreported change is pushed unless the FIFO was full.
  always_comb begin
    hit_s      = |(deb_s ^ rep_r);
    idx_s      = lowest_set(deb_s ^ rep_r);
    full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    push_s     = hit_s && !full_s;
    pop_s      = bus.rd_en && (count_r != {CNT_W{1'b0}});
    next_rep_s = rep_r;
    if (push_s) begin
      next_rep_s[idx_s] = deb_s[idx_s];
    end else begin
      next_rep_s = rep_r;
    end
    evt_s = make_event(idx_s, deb_s[idx_s], next_rep_s);
  end

  // Event storage; unread entries are gated by count so it needs no reset.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r] <= evt_s;
    end
  end

  // Pointers, occupancy, reported levels, stall and the show-ahead head word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_r     <= '0;
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      stall_r   <= 1'b0;
      rd_data_r <= 16'h0000;
    end else begin
      rep_r <= next_rep_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (hit_s && full_s) begin
        stall_r <= 1'b1;
      end else if (bus.clr_stall) begin
        stall_r <= 1'b0;
      end
      rd_data_r <= (count_r != {CNT_W{1'b0}}) ? mem_r[rd_ptr_r] : 16'h0000;
    end
  end

`ifdef SNES_BUTTON_EVENTS_IRQ_EN
  logic irq_r;

  // Interrupt follows FIFO non-empty, one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (count_r != {CNT_W{1'b0}});
    end
  end

  assign bus.irq = irq_r;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.rd_data = rd_data_r;
  assign bus.count   = count_r;
  assign bus.state   = deb_s;
  assign bus.stall   = stall_r;
endmodule

// File: tb/tb_snes_button_events.sv
// Directed bench for snes_button_events with DEBOUNCE_CYCLES=4, FIFO_DEPTH=8;
// expected event words are queued when buttons change and checked as they are popped.
module tb_snes_button_events;
  localparam int DEB = 4;
  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [5:0] buttons;
  int         total;
  int         bad;
  logic [15:0] exp_q[$];
  logic [5:0]  model_rep;
  logic [5:0]  cur_buttons;

  snes_button_events_if #(.FIFO_DEPTH(DEPTH)) bus ();

  snes_button_events #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .buttons(buttons),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] evt(input int idx, input logic press, input logic [5:0] after);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {1'b1, press, 3'b000, i3, 2'b00, after};
  endfunction

  // Drive a new level set, let it settle, and queue the events it should produce.
  task automatic set_buttons(input logic [5:0] v);
    buttons = v;
    cur_buttons = v;
    tick(DEB + 10);
    for (int i = 0; i < 6; i++) begin
      if (v[i] != model_rep[i]) begin
        model_rep[i] = v[i];
        exp_q.push_back(evt(i, v[i], model_rep));
      end
    end
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: got %h want <queue empty>", tag, bus.rd_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.rd_data, e);
    end
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    tick(1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_rep = 6'b000000;
    cur_buttons = 6'b000000;
    buttons = 6'b000000;
    bus.rd_en = 1'b0;
    bus.clr_stall = 1'b0;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("rst_rd_data", bus.rd_data, 16'h0000);
    chk("rst_count", 16'(bus.count), 16'h0000);
    chk("rst_state", 16'(bus.state), 16'h0000);
    chk("rst_stall", 16'(bus.stall), 16'h0000);
    chk("rst_irq", 16'(bus.irq), 16'h0000);

    // A press: exact debounce latency and event word timing.
    buttons = 6'b100000;
    cur_buttons = 6'b100000;
    tick(DEB + 1);
    chk("a_state_early", 16'(bus.state), 16'h0000);
    tick(1);
    chk("a_state", 16'(bus.state), 16'h0020);
    tick(1);
    chk("a_count", 16'(bus.count), 16'h0001);
    chk("a_rd_early", bus.rd_data, 16'h0000);
    tick(1);
    chk("a_rd_literal", bus.rd_data, 16'hC520);
`ifdef SNES_BUTTON_EVENTS_IRQ_EN
    chk("a_irq", 16'(bus.irq), 16'h0001);
`else
    chk("a_irq", 16'(bus.irq), 16'h0000);
`endif
    model_rep[5] = 1'b1;
    exp_q.push_back(evt(5, 1'b1, 6'b100000));
    pop_check("a_evt");
    chk("a_pop_count", 16'(bus.count), 16'h0000);
    chk("a_pop_rd", bus.rd_data, 16'h0000);

    set_buttons(6'b000000);
    pop_check("a_release");

    // B and UP together: drain lowest index first.
    set_buttons(6'b000011);
    chk("bu_count", 16'(bus.count), 16'h0002);
    chk("bu_head_literal", bus.rd_data, 16'hC001);
    pop_check("bu_first");
    chk("bu_second_literal", bus.rd_data, 16'hC103);
    pop_check("bu_second");

    // Three-cycle glitch on DOWN must not pass the debouncer.
    buttons = 6'b000111;
    tick(3);
    buttons = 6'b000011;
    tick(DEB + 10);
    chk("glitch_state", 16'(bus.state), 16'h0003);
    chk("glitch_count", 16'(bus.count), 16'h0000);
    chk("glitch_rd", bus.rd_data, 16'h0000);

    // Read while empty is ignored.
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    tick(2);
    chk("empty_rd_count", 16'(bus.count), 16'h0000);
    chk("empty_rd_data", bus.rd_data, 16'h0000);

    // Nine toggles with no reads: FIFO fills, the ninth is deferred.
    for (int k = 0; k < 9; k++) set_buttons(cur_buttons ^ 6'b000100);
    chk("full_count", 16'(bus.count), 16'h0008);
    chk("full_stall", 16'(bus.stall), 16'h0001);
    pop_check("full_first");
    tick(2);
    chk("refill_count", 16'(bus.count), 16'h0008);
    chk("stall_held", 16'(bus.stall), 16'h0001);
    bus.clr_stall = 1'b1;
    tick(1);
    bus.clr_stall = 1'b0;
    tick(1);
    chk("stall_clr", 16'(bus.stall), 16'h0000);
    for (int k = 0; k < 8; k++) pop_check($sformatf("drain%0d", k));
    chk("drain_count", 16'(bus.count), 16'h0000);
    chk("drain_rd", bus.rd_data, 16'h0000);
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
